// File: rtl/lsu_mem.sv
// Load/store unit with a private word-organised memory.
// Accepts one request at a time and walks it through BEAT0 (and BEAT1 for
// word-crossing accesses), each beat lasting RD_LATENCY cycles. It then holds
// the response in RESP until the consumer takes it. Errors are detected when
// the request is accepted and go straight to RESP without touching storage.
module lsu_mem #(
    parameter int DEPTH_WORDS      = 1024,
    parameter int RD_LATENCY       = 1,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic        req_sign,
    input  logic [1:0]  req_dw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [1:0]    dw_reg;
    logic          sign_reg;
    logic          store_reg;
    logic          cross_reg;
    logic          err_reg;
    logic [31:0]   lo_word_reg;
    logic [31:0]   rd_word_reg;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic [1:0]    size_m1;
    logic [32:0]   end_addr;
    logic          misaligned;
    logic          crossing;
    logic          req_bad;

    logic          in_beat;
    logic          beat_last;
    logic [1:0]    lane;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [3:0]    be_base;
    logic [7:0]    wide_be;
    logic [63:0]   wide_wdata;
    logic [3:0]    beat_be;
    logic [31:0]   beat_wdata;
    logic [63:0]   pair;
    logic [31:0]   raw;
    logic [31:0]   ext;

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = (state_reg == RESP) && err_reg;
    assign accept    = req_valid && req_ready;

    // Request classification: size, range, alignment and word crossing.
    // With ALLOW_MISALIGNED=0 any access not aligned to its own size is
    // rejected; that covers every word-crossing access and also a halfword
    // at an odd byte address.
    always_comb begin
        size_m1 = 2'd0;
        case (req_dw)
            2'd1:    size_m1 = 2'd1;
            2'd2:    size_m1 = 2'd3;
            default: size_m1 = 2'd0;
        endcase
        end_addr   = {1'b0, req_addr} + {31'b0, size_m1};
        misaligned = ((req_dw == 2'd1) && req_addr[0]) ||
                     ((req_dw == 2'd2) && (req_addr[1:0] != 2'd0));
        crossing   = ((req_dw == 2'd1) && (req_addr[1:0] == 2'd3)) ||
                     ((req_dw == 2'd2) && (req_addr[1:0] != 2'd0));
        req_bad    = (req_load == req_store) || (req_dw == 2'd3) ||
                     (end_addr >= MEM_BYTES) ||
                     ((ALLOW_MISALIGNED == 0) && misaligned);
    end

    // Beat addressing and store lane alignment (little-endian byte lanes).
    always_comb begin
        in_beat   = (state_reg == BEAT0) || (state_reg == BEAT1);
        beat_last = (cnt_reg == CW'(RD_LATENCY - 1));
        lane      = addr_reg[1:0];
        mem_addr  = addr_reg[AW+1:2] + {{(AW-1){1'b0}}, (state_reg == BEAT1)};
        mem_we    = in_beat && beat_last && store_reg;
        mem_re    = in_beat && beat_last && !store_reg;
        be_base   = 4'b1111;
        case (dw_reg)
            2'd0:    be_base = 4'b0001;
            2'd1:    be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
        wide_be    = {4'b0000, be_base} << lane;
        wide_wdata = {32'b0, wdata_reg} << {lane, 3'b000};
        beat_be    = (state_reg == BEAT1) ? wide_be[7:4] : wide_be[3:0];
        beat_wdata = (state_reg == BEAT1) ? wide_wdata[63:32] : wide_wdata[31:0];
    end

    // Storage: byte-enabled write and registered read on the last edge of a beat.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (beat_be[b]) begin
                    mem[mem_addr][b*8 +: 8] <= beat_wdata[b*8 +: 8];
                end
            end
        end
        if (mem_re) begin
            rd_word_reg <= mem[mem_addr];
        end
    end

    // Load result: shift the beat pair down to the access lane, then extend.
    always_comb begin
        pair = {rd_word_reg, (cross_reg ? lo_word_reg : rd_word_reg)};
        raw  = pair[{lane, 3'b000} +: 32];
        ext  = raw;
        case (dw_reg)
            2'd0:    ext = {{24{sign_reg & raw[7]}}, raw[7:0]};
            2'd1:    ext = {{16{sign_reg & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
        rsp_rdata = (state_reg == RESP && !err_reg && !store_reg) ? ext : 32'd0;
    end

    // Control FSM: capture at accept, count beat cycles, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            dw_reg      <= 2'd0;
            sign_reg    <= 1'b0;
            store_reg   <= 1'b0;
            cross_reg   <= 1'b0;
            err_reg     <= 1'b0;
            lo_word_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= req_addr[AW+1:0];
                        wdata_reg <= req_wdata;
                        dw_reg    <= req_dw;
                        sign_reg  <= req_sign;
                        store_reg <= req_store;
                        cross_reg <= crossing;
                        err_reg   <= req_bad;
                        cnt_reg   <= '0;
                        state_reg <= req_bad ? RESP : BEAT0;
                    end
                end
                BEAT0: begin
                    if (beat_last) begin
                        cnt_reg   <= '0;
                        state_reg <= cross_reg ? BEAT1 : RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BEAT1: begin
                    if (beat_last) begin
                        // rd_word_reg still holds the BEAT0 word on this edge
                        lo_word_reg <= rd_word_reg;
                        cnt_reg     <= '0;
                        state_reg   <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: three instances (RD_LATENCY=1, RD_LATENCY=3, and
// misaligned-rejecting) driven from one vector table, with a scoreboard
// queue holding the expected response of each issued request.
module tb_lsu_mem;

    logic        clk;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_load  [3];
    logic        req_store [3];
    logic        req_sign  [3];
    logic [1:0]  req_dw    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            lsu_mem #(
                .DEPTH_WORDS      (64),
                .RD_LATENCY       ((gi == 1) ? 3 : 1),
                .ALLOW_MISALIGNED ((gi == 2) ? 0 : 1)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .req_valid (req_valid[gi]),
                .req_ready (req_ready[gi]),
                .req_load  (req_load[gi]),
                .req_store (req_store[gi]),
                .req_sign  (req_sign[gi]),
                .req_dw    (req_dw[gi]),
                .req_addr  (req_addr[gi]),
                .req_wdata (req_wdata[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_ready (rsp_ready[gi]),
                .rsp_rdata (rsp_rdata[gi]),
                .rsp_err   (rsp_err[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          u;
        bit          ld;
        bit          st;
        bit          sgn;
        logic [1:0]  dw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        bit          err;
        int          lat;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   txn    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(int u, bit ld, bit st, bit sgn, logic [1:0] dw,
                                logic [31:0] a, logic [31:0] wd, logic [31:0] ed,
                                bit ee, int lat, int hold);
        vec_t v;
        v.u = u; v.ld = ld; v.st = st; v.sgn = sgn; v.dw = dw;
        v.addr = a; v.wdata = wd; v.exp_data = ed; v.exp_err = ee;
        v.exp_lat = lat; v.hold = hold;
        return v;
    endfunction

    // Issue one request, measure edges from accept to rsp_valid, compare
    // against the scoreboard, optionally hold the response, then retire it.
    task automatic run(input vec_t v);
        exp_t e;
        int   n;
        int   u;
        u = v.u;
        e.data = v.exp_data; e.err = v.exp_err; e.lat = v.exp_lat;
        sb.push_back(e);
        chk($sformatf("t%0d req_ready_idle", txn), 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1; req_load[u] = v.ld; req_store[u] = v.st;
        req_sign[u] = v.sgn; req_dw[u] = v.dw; req_addr[u] = v.addr;
        req_wdata[u] = v.wdata;
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        n = 0;
        while (rsp_valid[u] !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        chk($sformatf("t%0d latency", txn), 32'(n), 32'(e.lat));
        chk($sformatf("t%0d rsp_err", txn), 32'(rsp_err[u]), 32'(e.err));
        chk($sformatf("t%0d rsp_rdata", txn), rsp_rdata[u], e.data);
        $display("txn %0d inst %0d ld=%0b st=%0b dw=%0d addr=0x%08h edges=%0d rdata=0x%08h err=%0b",
                 txn, u, v.ld, v.st, v.dw, v.addr, n, rsp_rdata[u], rsp_err[u]);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("t%0d hold%0d rsp_valid", txn, h), 32'(rsp_valid[u]), 32'd1);
            chk($sformatf("t%0d hold%0d rsp_rdata", txn, h), rsp_rdata[u], e.data);
            chk($sformatf("t%0d hold%0d rsp_err", txn, h), 32'(rsp_err[u]), 32'(e.err));
            chk($sformatf("t%0d hold%0d req_ready", txn, h), 32'(req_ready[u]), 32'd0);
        end
        rsp_ready[u] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[u] = 1'b0;
        chk($sformatf("t%0d req_ready_after", txn), 32'(req_ready[u]), 32'd1);
        chk($sformatf("t%0d rsp_valid_after", txn), 32'(rsp_valid[u]), 32'd0);
        txn++;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_load[i] = 1'b0; req_store[i] = 1'b0;
            req_sign[i] = 1'b0; req_dw[i] = 2'd0; req_addr[i] = 32'd0;
            req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
        end
        rst_n = 1'b0;

        // Instance 0: RD_LATENCY=1, misaligned split into two beats
        vt.push_back(mk(0, 0, 1, 0, 2'd2, 32'd0,   32'h0102F3F4, 32'h00000000, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 1, 2'd0, 32'd0,   32'h0,        32'hFFFFFFF4, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd0, 32'd0,   32'h0,        32'h000000F4, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 1, 2'd1, 32'd0,   32'h0,        32'hFFFFF3F4, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd1, 32'd2,   32'h0,        32'h00000102, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'd0,   32'h0,        32'h0102F3F4, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 2'd2, 32'd4,   32'h00000000, 32'h00000000, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 2'd2, 32'd3,   32'hAABBCCDD, 32'h00000000, 0, 2, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'd0,   32'h0,        32'hDD02F3F4, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'd4,   32'h0,        32'h00AABBCC, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'd3,   32'h0,        32'hAABBCCDD, 0, 2, 0));
        vt.push_back(mk(0, 1, 0, 1, 2'd1, 32'd3,   32'h0,        32'hFFFFCCDD, 0, 2, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'd0,   32'h0,        32'hDD02F3F4, 0, 1, 5));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'd256, 32'h0,        32'h00000000, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2'd0, 32'd255, 32'hFFFFFFA5, 32'h00000000, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd0, 32'd255, 32'h0,        32'h000000A5, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 1, 2'd0, 32'd255, 32'h0,        32'hFFFFFFA5, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd1, 32'd255, 32'h0,        32'h00000000, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2'd2, 32'd8,   32'h55555555, 32'h00000000, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 2'd2, 32'd4,   32'h66666666, 32'h00000000, 0, 1, 0));
        // Instance 1: RD_LATENCY=3
        vt.push_back(mk(1, 0, 1, 0, 2'd2, 32'd0,   32'h0102F3F4, 32'h00000000, 0, 3, 0));
        vt.push_back(mk(1, 0, 1, 0, 2'd2, 32'd4,   32'h55667788, 32'h00000000, 0, 3, 0));
        vt.push_back(mk(1, 1, 0, 0, 2'd2, 32'd0,   32'h0,        32'h0102F3F4, 0, 3, 0));
        vt.push_back(mk(1, 1, 0, 0, 2'd2, 32'd2,   32'h0,        32'h77880102, 0, 6, 0));
        // Instance 2: misaligned accesses rejected
        vt.push_back(mk(2, 0, 1, 0, 2'd2, 32'd0,   32'h11223344, 32'h00000000, 0, 1, 0));
        vt.push_back(mk(2, 0, 1, 0, 2'd1, 32'd1,   32'h0000FFFF, 32'h00000000, 1, 0, 0));
        vt.push_back(mk(2, 1, 1, 0, 2'd2, 32'd0,   32'h00000000, 32'h00000000, 1, 0, 0));
        vt.push_back(mk(2, 0, 1, 0, 2'd3, 32'd0,   32'h00000000, 32'h00000000, 1, 0, 0));
        vt.push_back(mk(2, 0, 0, 0, 2'd2, 32'd0,   32'h00000000, 32'h00000000, 1, 0, 0));
        vt.push_back(mk(2, 0, 1, 0, 2'd2, 32'd256, 32'h00000000, 32'h00000000, 1, 0, 0));
        vt.push_back(mk(2, 1, 0, 0, 2'd2, 32'd0,   32'h0,        32'h11223344, 0, 1, 0));
        vt.push_back(mk(2, 1, 0, 0, 2'd0, 32'd3,   32'h0,        32'h00000011, 0, 1, 0));
        vt.push_back(mk(2, 1, 0, 0, 2'd1, 32'd2,   32'h0,        32'h00001122, 0, 1, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d req_ready", i), 32'(req_ready[i]), 32'd1);
            chk($sformatf("rst%0d rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
            chk($sformatf("rst%0d rsp_rdata", i), rsp_rdata[i], 32'd0);
            chk($sformatf("rst%0d rsp_err", i), 32'(rsp_err[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[k]) run(vt[k]);

        // Reset during BEAT1 of a crossing store: word 1 committed, word 2 not
        req_valid[0] = 1'b1; req_load[0] = 1'b0; req_store[0] = 1'b1;
        req_sign[0] = 1'b0; req_dw[0] = 2'd2; req_addr[0] = 32'd7;
        req_wdata[0] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("midrst beat0 rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        chk("midrst beat1 req_ready", 32'(req_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst req_ready", 32'(req_ready[0]), 32'd1);
        chk("midrst rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("midrst rsp_rdata", rsp_rdata[0], 32'd0);
        chk("midrst rsp_err", 32'(rsp_err[0]), 32'd0);
        $display("txn %0d inst 0 store dw=2 addr=0x00000007 aborted by reset in BEAT1", txn);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(mk(0, 1, 0, 0, 2'd2, 32'd4, 32'h0, 32'h78666666, 0, 1, 0));
        run(mk(0, 1, 0, 0, 2'd2, 32'd8, 32'h0, 32'h55555555, 0, 1, 0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
